// File: rtl/ks_bus_pkg.sv
// Shared definitions for the KSZ8851 host bus engine: phase encoding,
// idle strobe levels and the command-word builder.
package ks_bus_pkg;

   // Phase encoding is also decoded by the transmission sequencer.
   typedef enum logic [3:0] {
      ST_ADDR0  = 4'd0,
      ST_ADDR1  = 4'd1,
      ST_ADDR2  = 4'd2,
      ST_READ0  = 4'd3,
      ST_READ1  = 4'd4,
      ST_READ2  = 4'd5,
      ST_WRITE0 = 4'd6,
      ST_WRITE1 = 4'd7,
      ST_WRITE2 = 4'd8,
      ST_WAIT   = 4'd9
   } ks_state_e;

   localparam logic CSN_IDLE = 1'b1;
   localparam logic CMD_IDLE = 1'b0;
   localparam logic RDN_IDLE = 1'b1;
   localparam logic WRN_IDLE = 1'b1;

   // Command word {BE[3:0], 4'b0000, offset}. Word accesses enable the
   // half selected by offset[1]; byte accesses enable one lane.
   function automatic logic [15:0] ks_cmd_word(input logic [7:0] offset,
                                               input logic       length);
      logic [3:0] be;
      if (length) be = offset[1] ? 4'b1100 : 4'b0011;
      else        be = 4'b0001 << offset[1:0];
      return {be, 4'b0000, offset};
   endfunction

endpackage

// File: rtl/ks_host_bus_sd_iobuf.sv
// Tristate buffer for the shared SD pins; keeps the inout handling in one
// place so synthesis and simulation see the same structure.
module ks_sd_iobuf (
   inout  wire  [15:0] pad,
   input  logic [15:0] sd_out,
   input  logic        sd_oe,
   output logic [15:0] sd_in
);

   // Drive the pad only when enabled; otherwise release it.
   assign pad   = sd_oe ? sd_out : 16'hzzzz;
   assign sd_in = pad;

endmodule

// File: rtl/ks_host_bus.sv
// Bus-cycle engine for the KSZ8851 16-bit host interface.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ADDR0  | CMD=1, command word built from live inputs on SD
// ADDR1  | WRN low for STROBE_CYCLES, captured command word on SD
// ADDR2  | WRN high, command word held; branch on captured WR
// READ0  | RDN low for STROBE_CYCLES, SD released
// READ1  | RDN low, readData sampled on exit
// READ2  | RDN high, entry rule applied
// WRITE0 | WRN low for STROBE_CYCLES, writeData on SD
// WRITE1 | WRN low, writeData on SD
// WRITE2 | WRN high, writeData held, entry rule applied
// WAIT   | idle, CSN high, SD released
module ks_host_bus
   import ks_bus_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic        clk40m,
   input  logic        reset,
   input  logic        NewCommand,
   input  logic        Dummy_Write,
   input  logic        WR,
   input  logic [7:0]  offset,
   input  logic        length,
   input  logic [15:0] writeData,
   output logic [3:0]  state,
   output logic [15:0] readData,
   output logic        ks_csn,
   output logic        ks_cmd,
   output logic        ks_rdn,
   output logic        ks_wrn,
   inout  wire  [15:0] ks_sd
);

   localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

   ks_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        wr_q;
   logic [15:0] cmd_q;
   logic [15:0] read_data_q;
   logic        csn_q, cmd_q_o, rdn_q, wrn_q, sd_oe_q;
   logic        csn_d, cmd_d, rdn_d, wrn_d, sd_oe_d;
   logic [15:0] sd_out;
   logic [15:0] sd_in;

   // Next-phase decode; strobe levels follow the phase being entered so
   // they switch on the same edge as the published state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT, ST_READ2, ST_WRITE2: begin
            if (!NewCommand)     state_d = ST_WAIT;
            else if (Dummy_Write) state_d = ST_WRITE0;
            else                 state_d = ST_ADDR0;
         end
         ST_ADDR0:  state_d = ST_ADDR1;
         ST_ADDR1:  if (cnt_q == '0) state_d = ST_ADDR2;
         ST_ADDR2:  state_d = wr_q ? ST_WRITE0 : ST_READ0;
         ST_READ0:  if (cnt_q == '0) state_d = ST_READ1;
         ST_READ1:  state_d = ST_READ2;
         ST_WRITE0: if (cnt_q == '0) state_d = ST_WRITE1;
         ST_WRITE1: state_d = ST_WRITE2;
         default:   state_d = ST_WAIT;
      endcase

      // Down-counter reloads on every phase change; only the stretched
      // phases ever wait on terminal count.
      cnt_d = cnt_q;
      if (state_d != state_q)  cnt_d = CNT_LOAD;
      else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;

      csn_d   = (state_d == ST_WAIT);
      cmd_d   = (state_d == ST_ADDR0) || (state_d == ST_ADDR1) ||
                (state_d == ST_ADDR2);
      rdn_d   = !((state_d == ST_READ0) || (state_d == ST_READ1));
      wrn_d   = !((state_d == ST_ADDR1) || (state_d == ST_WRITE0) ||
                  (state_d == ST_WRITE1));
      sd_oe_d = cmd_d || (state_d == ST_WRITE0) || (state_d == ST_WRITE1) ||
                (state_d == ST_WRITE2);
   end

   // SD data source: live command word in ADDR0, captured one through the
   // rest of the address phase, live writeData during the data phase.
   always_comb begin
      sd_out = 16'h0000;
      case (state_q)
         ST_ADDR0:                       sd_out = ks_cmd_word(offset, length);
         ST_ADDR1, ST_ADDR2:             sd_out = cmd_q;
         ST_WRITE0, ST_WRITE1, ST_WRITE2: sd_out = writeData;
         default:                        sd_out = 16'h0000;
      endcase
   end

   // Phase, counter, captures and registered strobes.
   always_ff @(posedge clk40m) begin
      if (!reset) begin
         state_q     <= ST_WAIT;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         cmd_q       <= 16'h0000;
         read_data_q <= 16'h0000;
         csn_q       <= CSN_IDLE;
         cmd_q_o     <= CMD_IDLE;
         rdn_q       <= RDN_IDLE;
         wrn_q       <= WRN_IDLE;
         sd_oe_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_ADDR0) begin
            wr_q  <= WR;
            cmd_q <= ks_cmd_word(offset, length);
         end
         if (state_q == ST_READ1) read_data_q <= sd_in;
         csn_q   <= csn_d;
         cmd_q_o <= cmd_d;
         rdn_q   <= rdn_d;
         wrn_q   <= wrn_d;
         sd_oe_q <= sd_oe_d;
      end
   end

   ks_sd_iobuf u_sd_iobuf (
      .pad    (ks_sd),
      .sd_out (sd_out),
      .sd_oe  (sd_oe_q),
      .sd_in  (sd_in)
   );

   assign state    = state_q;
   assign readData = read_data_q;
   assign ks_csn   = csn_q;
   assign ks_cmd   = cmd_q_o;
   assign ks_rdn   = rdn_q;
   assign ks_wrn   = wrn_q;

endmodule
